// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller: state encoding,
// status colours and the output-width helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_BEGIN    = 3'd0,
        ST_PLAY     = 3'd1,
        ST_HIT      = 3'd2,
        ST_LVL_DONE = 3'd3,
        ST_LOST     = 3'd4,
        ST_WON      = 3'd5,
        ST_PAUSED   = 3'd6,
        ST_ILLEGAL  = 3'd7
    } state_e;

    localparam logic [2:0] COL_IDLE     = 3'b110;
    localparam logic [2:0] COL_HIT      = 3'b101;
    localparam logic [2:0] COL_LVL_DONE = 3'b011;
    localparam logic [2:0] COL_LOST     = 3'b100;
    localparam logic [2:0] COL_WON      = 3'b010;
    localparam logic [2:0] COL_PAUSED   = 3'b001;

    // Level index needs at least one bit even for a single-level game.
    function automatic int level_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lives counter must hold 0..n inclusive.
    function automatic int lives_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [2:0] state_col(input state_e s);
        case (s)
            ST_HIT:      return COL_HIT;
            ST_LVL_DONE: return COL_LVL_DONE;
            ST_LOST:     return COL_LOST;
            ST_WON:      return COL_WON;
            ST_PAUSED:   return COL_PAUSED;
            default:     return COL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_fsm_hold_timer.sv
// Down-counter that times the result-hold states. load arms it with
// HOLD_CYCLES-1; done is high while the count sits at zero.
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic done
);
    localparam int TW = (HOLD_CYCLES <= 1) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] LOAD_VAL = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Load wins over counting; the count saturates at zero.
    always_comb begin
        timer_d = timer_q;
        if (load)
            timer_d = LOAD_VAL;
        else if (count && timer_q != '0)
            timer_d = timer_q - 1'b1;
    end

    // Timer register.
    always_ff @(posedge clock) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign done = (timer_q == '0);

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game-flow controller: level/lives sequencing with timed result
// states. Define GAME_PAUSE_EN to add the pause port and PAUSED state.
module game_flow_fsm
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 3,
    parameter int NUM_LIVES   = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int COL_W       = 3,
    localparam int LEVEL_W    = level_w(NUM_LEVELS),
    localparam int LIVES_W    = lives_w(NUM_LIVES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               user_input,
    input  logic               collided,
    input  logic               reached_screen_end,
`ifdef GAME_PAUSE_EN
    input  logic               pause,
`endif
    output logic [COL_W-1:0]   col,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               level_start,
    output logic [2:0]         state
);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);

    state_e               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 level_start_q, level_start_d;
    logic                 tmr_load, tmr_done, holding;

    assign holding = (state_q == ST_HIT)  || (state_q == ST_LVL_DONE) ||
                     (state_q == ST_LOST) || (state_q == ST_WON);

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .count (holding),
        .done  (tmr_done)
    );

    // Next state, level/lives update and level_start generation.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        tmr_load = 1'b0;
        case (state_q)
            ST_BEGIN: if (user_input) state_d = ST_PLAY;
            ST_PLAY: begin
`ifdef GAME_PAUSE_EN
                if (pause) state_d = ST_PAUSED;
                else
`endif
                if (collided) begin
                    tmr_load = 1'b1;
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_LOST;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        state_d = ST_HIT;
                    end
                end else if (reached_screen_end) begin
                    tmr_load = 1'b1;
                    if (level_q >= LAST_LEVEL) begin
                        state_d = ST_WON;
                    end else begin
                        level_d = level_q + 1'b1;
                        state_d = ST_LVL_DONE;
                    end
                end
            end
            ST_HIT, ST_LVL_DONE: if (tmr_done) state_d = ST_PLAY;
            ST_LOST, ST_WON:     if (tmr_done) state_d = ST_BEGIN;
`ifdef GAME_PAUSE_EN
            ST_PAUSED:           if (pause) state_d = ST_PLAY;
`endif
            default:             state_d = ST_BEGIN;
        endcase
        // Entering or sitting in BEGIN always presents a fresh game.
        if (state_d == ST_BEGIN) begin
            lives_d = FULL_LIVES;
            level_d = '0;
        end
        // Resuming from PAUSED is not a level (re)start.
        level_start_d = (state_d == ST_PLAY) &&
                        ((state_q == ST_BEGIN) || (state_q == ST_HIT) ||
                         (state_q == ST_LVL_DONE));
    end

    // State, counters and registered level_start pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BEGIN;
            level_q       <= '0;
            lives_q       <= FULL_LIVES;
            level_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            level_start_q <= level_start_d;
        end
    end

    assign col         = COL_W'(state_col(state_q));
    assign level       = level_q;
    assign lives       = lives_q;
    assign level_start = level_start_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: two instances (hold 4 and hold 1) share stimulus
// and are compared every cycle against an event-level reference model.
module tb_game_flow_fsm;
    localparam int NL = 3;
    localparam int NV = 2;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, user_input, collided, reached_screen_end, pause;
    logic [2:0] col_o [2];
    logic [1:0] lvl_o [2];
    logic [1:0] liv_o [2];
    logic       ls_o  [2];
    logic [2:0] st_o  [2];

    int nchk = 0;
    int nerr = 0;
    int cyc_n = 0;

    always #5 clock = ~clock;

    game_flow_fsm #(.NUM_LEVELS(NL), .NUM_LIVES(NV), .HOLD_CYCLES(4), .COL_W(3)) dut4 (
        .clock(clock), .reset(reset), .user_input(user_input), .collided(collided),
        .reached_screen_end(reached_screen_end),
`ifdef GAME_PAUSE_EN
        .pause(pause),
`endif
        .col(col_o[0]), .level(lvl_o[0]), .lives(liv_o[0]), .level_start(ls_o[0]),
        .state(st_o[0]));

    game_flow_fsm #(.NUM_LEVELS(NL), .NUM_LIVES(NV), .HOLD_CYCLES(1), .COL_W(3)) dut1 (
        .clock(clock), .reset(reset), .user_input(user_input), .collided(collided),
        .reached_screen_end(reached_screen_end),
`ifdef GAME_PAUSE_EN
        .pause(pause),
`endif
        .col(col_o[1]), .level(lvl_o[1]), .lives(liv_o[1]), .level_start(ls_o[1]),
        .state(st_o[1]));

    // Reference model: phase name, level, lives, remaining dwell, start pulse.
    typedef enum int {P_BEGIN, P_PLAY, P_HIT, P_DONE, P_LOST, P_WON, P_PAUSED} phase_t;
    phase_t m_ph [2];
    int     m_lv [2], m_lf [2], m_rem [2];
    bit     m_ls [2];

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int enc_of(input phase_t p);
        case (p)
            P_BEGIN: return 0;  P_PLAY: return 1;  P_HIT: return 2;
            P_DONE:  return 3;  P_LOST: return 4;  P_WON: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int col_of(input phase_t p);
        case (p)
            P_HIT:    return 5;
            P_DONE:   return 3;
            P_LOST:   return 4;
            P_WON:    return 2;
            P_PAUSED: return 1;
            default:  return 6;
        endcase
    endfunction

    task automatic mstep(input int k, input bit u, input bit c, input bit e,
                         input bit p, input bit r);
        bit start = 1'b0;
        if (r) begin
            m_ph[k] = P_BEGIN; m_lv[k] = 0; m_lf[k] = NV; m_rem[k] = 0; m_ls[k] = 1'b0;
            return;
        end
        case (m_ph[k])
            P_BEGIN: if (u) begin m_ph[k] = P_PLAY; start = 1'b1; end
            P_PLAY: begin
                if (PAUSE_EN && p) m_ph[k] = P_PAUSED;
                else if (c) begin
                    m_lf[k] = m_lf[k] - 1;
                    m_ph[k] = (m_lf[k] == 0) ? P_LOST : P_HIT;
                    m_rem[k] = hold_of(k);
                end else if (e) begin
                    if (m_lv[k] == NL - 1) m_ph[k] = P_WON;
                    else begin m_lv[k]++; m_ph[k] = P_DONE; end
                    m_rem[k] = hold_of(k);
                end
            end
            P_PAUSED: if (p) m_ph[k] = P_PLAY;
            default: begin
                m_rem[k]--;
                if (m_rem[k] == 0) begin
                    if (m_ph[k] == P_HIT || m_ph[k] == P_DONE) begin
                        m_ph[k] = P_PLAY; start = 1'b1;
                    end else begin
                        m_ph[k] = P_BEGIN; m_lv[k] = 0; m_lf[k] = NV;
                    end
                end
            end
        endcase
        m_ls[k] = start;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_n, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("state[%0d]", k), int'(st_o[k]),  enc_of(m_ph[k]));
            chk($sformatf("col[%0d]", k),   int'(col_o[k]), col_of(m_ph[k]));
            chk($sformatf("level[%0d]", k), int'(lvl_o[k]), m_lv[k]);
            chk($sformatf("lives[%0d]", k), int'(liv_o[k]), m_lf[k]);
            chk($sformatf("lstart[%0d]", k), int'(ls_o[k]), int'(m_ls[k]));
        end
    endtask

    // One clock: drive inputs, advance DUTs and model, compare on falling edge.
    task automatic cyc(input bit u, input bit c, input bit e, input bit p, input bit r);
        user_input = u; collided = c; reached_screen_end = e; pause = p; reset = r;
        @(posedge clock);
        for (int k = 0; k < 2; k++) mstep(k, u, c, e, p, r);
        @(negedge clock);
        cyc_n++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        user_input = 0; collided = 0; reached_screen_end = 0; pause = 0; reset = 1;
        @(negedge clock);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Full win path through every level.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); idle(4);
        cyc(0, 0, 1, 0, 0); idle(4);
        cyc(0, 0, 1, 0, 0); idle(5);

        // Collision on the last level beats screen end.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); idle(4);
        cyc(0, 0, 1, 0, 0); idle(4);
        cyc(0, 1, 1, 0, 0);
        chk("t4_state", int'(st_o[0]), 2);
        chk("t4_level", int'(lvl_o[0]), 2);
        chk("t4_lives", int'(liv_o[0]), 1);
        idle(4);
        chk("t4_back_play", int'(st_o[0]), 1);

        // Lose all lives, with events hammered during each hold.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_begin", int'(st_o[0]), 0);
        chk("t3_relives", int'(liv_o[0]), NV);

        // Reset mid-play with level 1, lives 1.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); idle(4);
        cyc(0, 1, 0, 0, 0); idle(5);
        cyc(1, 1, 1, 1, 1);
        chk("t1_state", int'(st_o[0]), 0);
        chk("t1_lives", int'(liv_o[0]), NV);
        chk("t1_level", int'(lvl_o[0]), 0);
        chk("t1_lstart", int'(ls_o[0]), 0);

        // Pause together with collision (model ignores pause when absent).
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);

        // Random soak.
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 59) == 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
